// File: rtl/sparc_tlu_penc_arb_if.sv
// Request/grant bundle for the TLU priority-encoder arbiter.
// The consumer side drives requests and ack; the arbiter drives the registered grant.
interface sparc_tlu_penc_arb_if #(
    parameter int WIDTH = 64,
    parameter int IDXW  = 6
) ();
    logic [WIDTH-1:0] req_in;
    logic             mode;
    logic             ack;
    logic             vld_out;
    logic [IDXW-1:0]  idx_out;
    logic [WIDTH-1:0] onehot_out;
    logic [IDXW-1:0]  ptr_out;

    modport master (
        output req_in, mode, ack,
        input  vld_out, idx_out, onehot_out, ptr_out
    );

    modport slave (
        input  req_in, mode, ack,
        output vld_out, idx_out, onehot_out, ptr_out
    );
endinterface

// File: rtl/sparc_tlu_penc_arb.sv
// Registered WIDTH-bit priority encoder / arbiter with fixed or round-robin priority.
// The grant is held under a valid/ack handshake, and every output comes straight from a flop.
module sparc_tlu_penc_arb #(
    parameter int WIDTH = 64,
    parameter int IDXW  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    sparc_tlu_penc_arb_if.slave     arb
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] onehot_q, onehot_d;
    logic [IDXW-1:0]  ptr_q, ptr_d;

    logic             accept;
    logic             evaluate;
    logic [IDXW-1:0]  ptrEff;
    logic [WIDTH-1:0] lowMask;
    logic [WIDTH-1:0] reqLow;
    logic [IDXW-1:0]  fixedIdx;
    logic [IDXW-1:0]  lowIdx;
    logic [IDXW-1:0]  winner;

    function automatic logic [IDXW-1:0] highestSet(input logic [WIDTH-1:0] v);
        highestSet = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) highestSet = IDXW'(i);
        end
    endfunction

    assign accept   = (state_q == HOLD) && arb.ack;
    assign evaluate = (state_q == IDLE) || arb.ack;
    // An ack cycle searches relative to the index being acked, not the stale pointer.
    assign ptrEff   = accept ? idx_q : ptr_q;

    always_comb begin
        lowMask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            lowMask[i] = (IDXW'(i) < ptrEff);
        end
    end

    // Round-robin: bits below ptr win first; otherwise the top of the vector, with ptr itself last.
    assign reqLow   = arb.req_in & lowMask;
    assign fixedIdx = highestSet(arb.req_in);
    assign lowIdx   = highestSet(reqLow);
    assign winner   = !arb.mode ? fixedIdx : ((|reqLow) ? lowIdx : fixedIdx);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        ptr_d    = ptr_q;
        if (accept) begin
            ptr_d = idx_q;
        end
        if (evaluate) begin
            if (|arb.req_in) begin
                state_d  = HOLD;
                idx_d    = winner;
                onehot_d = WIDTH'(1) << winner;
            end else begin
                state_d  = IDLE;
                idx_d    = '0;
                onehot_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            onehot_q <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            ptr_q    <= ptr_d;
        end
    end

    assign arb.vld_out    = (state_q == HOLD);
    assign arb.idx_out    = idx_q;
    assign arb.onehot_out = onehot_q;
    assign arb.ptr_out    = ptr_q;

endmodule

// File: tb/tb_sparc_tlu_penc_arb.sv
// Scoreboard bench for sparc_tlu_penc_arb: a 64-bit and a 5-bit instance driven by directed
// vectors; expected grants are queued by the stimulus and checked by an independent monitor.
module tb_sparc_tlu_penc_arb;

    logic clk = 1'b0;
    logic rst64 = 1'b1;
    logic rst5  = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    typedef struct {
        int          cyc;
        logic        vld;
        logic [7:0]  idx;
        logic [63:0] oh;
        logic [7:0]  ptr;
        string       name;
    } exp_t;

    exp_t q64[$];
    exp_t q5[$];

    sparc_tlu_penc_arb_if #(.WIDTH(64), .IDXW(6)) bus64 ();
    sparc_tlu_penc_arb_if #(.WIDTH(5),  .IDXW(3)) bus5 ();

    sparc_tlu_penc_arb #(.WIDTH(64), .IDXW(6)) dut64 (
        .clk (clk),
        .rst (rst64),
        .arb (bus64)
    );

    sparc_tlu_penc_arb #(.WIDTH(5), .IDXW(3)) dut5 (
        .clk (clk),
        .rst (rst5),
        .arb (bus5)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input exp_t e, input logic vld, input logic [7:0] idx,
                               input logic [63:0] oh, input logic [7:0] ptr, input int maxIdx);
        vectors++;
        if (vld !== e.vld || idx !== e.idx || oh !== e.oh || ptr !== e.ptr || int'(idx) > maxIdx) begin
            miscompares++;
            $display("[TB] FAIL %s cyc=%0d: got vld=%0b idx=%0d onehot=%h ptr=%0d, want vld=%0b idx=%0d onehot=%h ptr=%0d",
                     e.name, cyc, vld, idx, oh, ptr, e.vld, e.idx, e.oh, e.ptr);
        end
    endtask

    // Monitor: pop the expected record targeted at this cycle and compare it with the outputs.
    always @(negedge clk) begin
        if (q64.size() > 0 && q64[0].cyc == cyc) begin
            checkOutput(q64.pop_front(), bus64.vld_out, 8'(bus64.idx_out), bus64.onehot_out,
                        8'(bus64.ptr_out), 63);
        end
        if (q5.size() > 0 && q5[0].cyc == cyc) begin
            checkOutput(q5.pop_front(), bus5.vld_out, 8'(bus5.idx_out), 64'(bus5.onehot_out),
                        8'(bus5.ptr_out), 4);
        end
    end

    // Drive one cycle of inputs to the chosen instance and queue the outputs it must show next cycle.
    task automatic applyStimulus(input bit sel5, input logic r, input logic [63:0] req,
                                 input logic m, input logic a, input logic eVld,
                                 input int eIdx, input int ePtr, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        e.cyc  = cyc + 1;
        e.vld  = eVld;
        e.idx  = 8'(eIdx);
        e.oh   = eVld ? (64'd1 << eIdx) : 64'd0;
        e.ptr  = 8'(ePtr);
        e.name = nm;
        if (sel5) begin
            rst5        = r;
            bus5.req_in = req[4:0];
            bus5.mode   = m;
            bus5.ack    = a;
            q5.push_back(e);
        end else begin
            rst64        = r;
            bus64.req_in = req;
            bus64.mode   = m;
            bus64.ack    = a;
            q64.push_back(e);
        end
    endtask

    localparam logic [64-1:0] B5  = 64'd1 << 5;
    localparam logic [64-1:0] B20 = 64'd1 << 20;
    localparam logic [64-1:0] B40 = 64'd1 << 40;
    localparam logic [64-1:0] B63 = 64'd1 << 63;
    localparam logic [64-1:0] B33 = 64'd1 << 33;

    initial begin
        bus64.req_in = '0;
        bus64.mode   = 1'b0;
        bus64.ack    = 1'b0;
        bus5.req_in  = '0;
        bus5.mode    = 1'b0;
        bus5.ack     = 1'b0;

        // Reset and empty vector
        applyStimulus(0, 1, 64'd0, 0, 0, 0, 0, 0, "reset0");
        applyStimulus(0, 1, 64'd0, 0, 1, 0, 0, 0, "reset1");
        applyStimulus(0, 0, 64'd0, 0, 1, 0, 0, 0, "empty0");
        applyStimulus(0, 0, 64'd0, 0, 0, 0, 0, 0, "empty1");

        // Fixed priority: bit 63 keeps winning while still set
        applyStimulus(0, 0, 64'h8000_0000_0000_0011, 0, 1, 1, 63, 0,  "fixed_first");
        applyStimulus(0, 0, 64'h8000_0000_0000_0011, 0, 1, 1, 63, 63, "fixed_rewin0");
        applyStimulus(0, 0, 64'h8000_0000_0000_0011, 0, 1, 1, 63, 63, "fixed_rewin1");
        applyStimulus(0, 0, 64'h0000_0000_0000_0011, 0, 1, 1, 4,  63, "fixed_clear63");
        applyStimulus(0, 0, 64'd0,                  0, 1, 0, 0,  4,  "fixed_ack_empty");

        // Round-robin rotation over {5,20,40}; first grant in fixed mode
        applyStimulus(0, 0, B5 | B20 | B40, 0, 0, 1, 40, 4,  "rr_first_fixed");
        applyStimulus(0, 0, B5 | B20 | B40, 1, 1, 1, 20, 40, "rr_20");
        applyStimulus(0, 0, B5 | B20 | B40, 1, 1, 1, 5,  20, "rr_5");
        applyStimulus(0, 0, B5 | B20 | B40, 1, 1, 1, 40, 5,  "rr_wrap_40");
        applyStimulus(0, 0, B5 | B20 | B40, 1, 1, 1, 20, 40, "rr_20_again");

        // Hold: idx 20 frozen while requests change and ack stays low
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, B63, (i % 2 == 0), 0, 1, 20, 40, "hold_frozen");
        end
        applyStimulus(0, 0, B63, 1, 1, 1, 63, 20, "hold_release");
        applyStimulus(0, 0, 64'd0, 1, 1, 0, 0, 63, "hold_drain");

        // Reset mid-hold, with ack high to show reset overriding it
        applyStimulus(0, 0, B33 | (64'd1 << 10), 1, 0, 1, 33, 63, "pre_reset_grant");
        applyStimulus(0, 1, B33 | (64'd1 << 10), 1, 1, 0, 0,  0,  "reset_mid_hold");
        applyStimulus(0, 0, B33 | (64'd1 << 10) | 64'd4, 1, 0, 1, 33, 0,  "post_reset_first");
        applyStimulus(0, 0, B33 | (64'd1 << 10) | 64'd4, 1, 1, 1, 10, 33, "post_reset_rr");
        applyStimulus(0, 0, 64'd0, 1, 1, 0, 0, 10, "post_reset_drain");

        // WIDTH=5 round-robin: wrap and lone-request re-grant
        applyStimulus(1, 1, 64'd0,  1, 0, 0, 0, 0, "w5_reset");
        applyStimulus(1, 0, 64'h11, 1, 0, 1, 4, 0, "w5_first_4");
        applyStimulus(1, 0, 64'h11, 1, 1, 1, 0, 4, "w5_then_0");
        applyStimulus(1, 0, 64'h01, 1, 1, 1, 0, 0, "w5_lone_regrant");
        applyStimulus(1, 0, 64'h01, 1, 1, 1, 0, 0, "w5_lone_again");
        applyStimulus(1, 0, 64'h06, 1, 1, 1, 2, 0, "w5_wrap_2");
        applyStimulus(1, 0, 64'h06, 1, 1, 1, 1, 2, "w5_1");
        applyStimulus(1, 0, 64'd0,  1, 1, 0, 0, 1, "w5_drain");

        for (int i = 0; i < 5 && (q64.size() > 0 || q5.size() > 0); i++) begin
            @(posedge clk);
        end
        if (q64.size() > 0 || q5.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, want 0", q64.size() + q5.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sparc_tlu_penc_arb.md
# sparc_tlu_penc_arb

Parametrised, registered successor to the TLU 64->6 priority encoder. It picks one set bit of a WIDTH-bit request vector and reports its index and one-hot form, using either fixed priority (highest index wins) or round-robin priority. The result is held stable under a valid/ack handshake. It sits in the TLU wherever a pending-source vector (traps, interrupts, thread requests) must be serialised to one consumer.

## Interface
- WIDTH, 64, request vector width; legal range 2..64.
- IDXW, 6, index width; must equal ceil(log2(WIDTH)).
- clk  in  1  single clock; every flop is posedge clk.
- rst  in  1  reset, synchronous and active-high.
- req_in  in  WIDTH  request vector; bit i set means source i is pending.
- mode  in  1  0 = fixed priority (bit WIDTH-1 highest), 1 = round-robin.
- ack  in  1  consumer accepts the current grant; ignored when vld_out=0.
- vld_out  out  1  grant valid.
- idx_out  out  IDXW  index of the granted bit.
- onehot_out  out  WIDTH  one-hot form of idx_out; all-zero when vld_out=0.
- ptr_out  out  IDXW  current round-robin pointer (debug/visibility).

## Operation
- State machine has two states:
  - IDLE: vld_out=0.
  - HOLD: vld_out=1; idx_out and onehot_out are frozen.
- Evaluation happens in IDLE every cycle, and in HOLD on a cycle with ack=1.
- An evaluation samples req_in and mode on that cycle:
  - At least one bit set: load the winner into idx_out/onehot_out, go to (or stay in) HOLD.
  - No bit set: go to IDLE, with idx_out=0 and onehot_out=0.
- Fixed mode winner: highest set index. This matches the legacy encoder; the only difference is that the legacy encoder drove 0 with no valid when the vector was empty.
- Round-robin winner: search downward from ptr-1, wrapping to WIDTH-1 after index 0, and continue down to ptr inclusive. The first set bit found wins.
  - ptr itself therefore has the lowest priority.
  - A lone request at ptr is still granted.
- Pointer update:
  - ptr is loaded with idx_out only on an accepted grant (vld_out & ack).
  - ptr updates in both modes, so switching to round-robin continues from the last grant.
  - The evaluation on an ack cycle uses the updated ptr, i.e. the index being acked.
- Pointer reset value: ptr=0. The first round-robin search therefore starts at WIDTH-1, which is identical to fixed priority.
- WIDTH not a power of two: wrap goes from index 0 to WIDTH-1. idx_out and ptr_out never exceed WIDTH-1.
- Changes to req_in or mode while in HOLD with ack=0 have no effect on the outputs. A withdrawn request stays granted until it is acked.
- Clearing the acked source is the consumer's job. If the acked bit is still set, it is re-evaluated like any other bit:
  - Fixed mode: it can win again.
  - Round-robin: it wins only if it is the sole request.

## Timing
- Reset values:
  - vld_out=0, idx_out=0, onehot_out=0, ptr_out=0, state IDLE.
  - rst overrides ack and req_in in the same cycle.
- Latency: a request set at cycle N with the block in IDLE gives vld_out=1 at cycle N+1.
- Throughput: one grant per cycle when ack is held high and requests remain pending. Back-to-back grants have no bubble.
- Ack with an empty vector: vld_out=0 on the next cycle.
- rst asserted during HOLD: the grant is dropped with no ack and the pointer returns to 0 on the next cycle.
- All outputs are driven directly from flops, with no combinational path from input to output.
- The search is single-cycle combinational. It must close timing at WIDTH=64.

## Test plan
- Reset and empty vector: rst high for 2 cycles, then req_in=0 -> vld_out=0, idx_out=0, onehot_out=0, ptr_out=0 on every cycle.
- Fixed priority, WIDTH=64, mode=0: req_in=0x8000_0000_0000_0011, ack high -> idx 63, 63, 63... repeating. Then clear bit 63 -> idx 4.
- Round-robin rotation, mode=0 then 1: req_in with bits {5,20,40} held, ack every cycle -> idx sequence 40, 20, 5, 40, 20, with ptr_out following one cycle behind each accepted index.
- Hold under handshake: grant idx 20 with ack=0 for 5 cycles while req_in changes to bit 63 only -> idx_out stays 20 and vld_out stays 1. Then ack -> next idx 63.
- Non-power-of-two and lone request, WIDTH=5, IDXW=3, mode=1: after grants of 4 then 0, set req_in=5'b00001 -> idx 0 is re-granted, so the wrap stays within 0..4. No index ≥5 ever appears.
- Reset mid-hold: rst high during HOLD with idx 33 -> vld_out=0 and ptr_out=0 on the next cycle. The first grant after reset is the highest set bit.
